// File: rtl/xidoo_core.sv
// Tiny accumulator CPU: 8 opcodes, single-port synchronous-read memory,
// program loaded through the prog_* port while halted.
module xidoo_core #(
    parameter  int unsigned DW    = 8,
    localparam int unsigned AW    = DW - 3,
    localparam int unsigned DEPTH = 1 << AW
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          run,
    input  logic          prog_we,
    input  logic [AW-1:0] prog_addr,
    input  logic [DW-1:0] prog_data,
    input  logic [DW-1:0] in_data,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [DW-1:0] out_data,
    output logic          out_valid,
    output logic          aeq0,
    output logic          apos,
    output logic          halted
);

    typedef enum logic [2:0] {
        S_HALT, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_INWAIT
    } state_t;

    typedef enum logic [2:0] {
        OP_LOAD, OP_STORE, OP_ADD, OP_SUB, OP_IN, OP_JZ, OP_JPOS, OP_HALT
    } op_t;

    state_t        state, state_d;
    logic [AW-1:0] pc, pc_d;
    logic [DW-1:0] ir, ir_d;
    logic [DW-1:0] a, a_d;
    logic          out_valid_d;

    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] rdata;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [DW-1:0] mem_wdata;

    op_t           op;
    logic [AW-1:0] ir_addr;

    assign op       = op_t'(ir[DW-1:DW-3]);
    assign ir_addr  = ir[AW-1:0];

    assign out_data = a;
    assign aeq0     = (a == '0);
    assign apos     = ~a[DW-1];
    assign in_ready = (state == S_INWAIT);
    assign halted   = (state == S_HALT);

    // Next-state, datapath updates and memory port steering
    always_comb begin
        state_d     = state;
        pc_d        = pc;
        ir_d        = ir;
        a_d         = a;
        out_valid_d = 1'b0;
        mem_addr    = ir_addr;
        mem_we      = 1'b0;
        mem_wdata   = a;

        unique case (state)
            S_HALT: begin
                mem_addr  = prog_addr;
                mem_we    = prog_we;
                mem_wdata = prog_data;
                if (run) begin
                    pc_d    = '0;
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                mem_addr = pc;
                state_d  = S_DECODE;
            end
            S_DECODE: begin
                ir_d    = rdata;
                pc_d    = pc + AW'(1);
                state_d = S_EXEC;
            end
            S_EXEC: begin
                state_d = S_FETCH;
                case (op)
                    OP_LOAD:  state_d = S_MEM;
                    OP_ADD:   state_d = S_MEM;
                    OP_SUB:   state_d = S_MEM;
                    OP_STORE: mem_we  = 1'b1;
                    OP_IN:    state_d = S_INWAIT;
                    OP_JZ:    if (aeq0) pc_d = ir_addr;
                    OP_JPOS:  if (apos) pc_d = ir_addr;
                    OP_HALT:  state_d = S_HALT;
                endcase
            end
            S_MEM: begin
                state_d     = S_FETCH;
                out_valid_d = 1'b1;
                case (op)
                    OP_ADD:  a_d = a + rdata;
                    OP_SUB:  a_d = a - rdata;
                    default: a_d = rdata;
                endcase
            end
            S_INWAIT: begin
                if (in_valid) begin
                    a_d         = in_data;
                    out_valid_d = 1'b1;
                    state_d     = S_FETCH;
                end
            end
            default: state_d = S_HALT;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= S_HALT;
            pc        <= '0;
            ir        <= '0;
            a         <= '0;
            out_valid <= 1'b0;
        end else begin
            state     <= state_d;
            pc        <= pc_d;
            ir        <= ir_d;
            a         <= a_d;
            out_valid <= out_valid_d;
        end
    end

    // Program memory keeps its contents across reset
    always_ff @(posedge clock) begin
        if (mem_we) begin
            mem[mem_addr] <= mem_wdata;
        end
        rdata <= mem[mem_addr];
    end

endmodule

// File: tb/tb_xidoo_core.sv
// Bench for xidoo_core: directed program table, random programs against an
// instruction-level interpreter, async reset cases and a DW=10 instance.
module tb_xidoo_core;

    logic       clock;
    logic       reset;
    logic       run;
    logic       prog_we;
    logic [4:0] prog_addr;
    logic [7:0] prog_data;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] out_data;
    logic       out_valid;
    logic       aeq0;
    logic       apos;
    logic       halted;

    logic       w_run;
    logic       w_prog_we;
    logic [6:0] w_prog_addr;
    logic [9:0] w_prog_data;
    logic [9:0] w_in_data;
    logic       w_in_valid;
    logic       w_in_ready;
    logic [9:0] w_out_data;
    logic       w_out_valid;
    logic       w_aeq0;
    logic       w_apos;
    logic       w_halted;

    xidoo_core #(.DW(8)) dut (
        .clock(clock), .reset(reset), .run(run), .prog_we(prog_we),
        .prog_addr(prog_addr), .prog_data(prog_data), .in_data(in_data),
        .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data),
        .out_valid(out_valid), .aeq0(aeq0), .apos(apos), .halted(halted)
    );

    xidoo_core #(.DW(10)) dut10 (
        .clock(clock), .reset(reset), .run(w_run), .prog_we(w_prog_we),
        .prog_addr(w_prog_addr), .prog_data(w_prog_data), .in_data(w_in_data),
        .in_valid(w_in_valid), .in_ready(w_in_ready), .out_data(w_out_data),
        .out_valid(w_out_valid), .aeq0(w_aeq0), .apos(w_apos), .halted(w_halted)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [0:5][7:0] code;
        int              n;
        int              da0;
        logic [7:0]      dv0;
        int              da1;
        logic [7:0]      dv1;
        logic [7:0]      in_val;
        int              in_wait_c;
        bit              rst_first;
        logic [7:0]      exp_a;
        int              exp_pulses;
        int              exp_pc;
        int              exp_cycles;
    } vec_t;

    int checks;
    int failures;

    logic [7:0] sh [32];       // what the bench believes memory holds
    logic [7:0] m_mem [32];    // interpreter memory
    logic [7:0] m_a;
    logic [4:0] m_pc;
    int         m_cyc;
    int         m_pulses;
    logic [7:0] exp_q [$];
    logic [7:0] in_vals [32];
    int         in_wait [32];
    vec_t       tbl [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [0:5][7:0] code, input int n,
                                input int da0, input logic [7:0] dv0,
                                input int da1, input logic [7:0] dv1,
                                input logic [7:0] iv, input int iw, input bit rf,
                                input logic [7:0] ea, input int ep, input int epc,
                                input int ec);
        vec_t v;
        v.code = code; v.n = n; v.da0 = da0; v.dv0 = dv0; v.da1 = da1; v.dv1 = dv1;
        v.in_val = iv; v.in_wait_c = iw; v.rst_first = rf; v.exp_a = ea;
        v.exp_pulses = ep; v.exp_pc = epc; v.exp_cycles = ec;
        return v;
    endfunction

    // Instruction-level interpreter: each step is one whole instruction
    task automatic model_run();
        logic [7:0] w;
        logic [2:0] op;
        logic [4:0] ad;
        int         k;
        m_pc = 5'd0; m_cyc = 0; m_pulses = 0; k = 0;
        exp_q.delete();
        for (int s = 0; s < 1000; s++) begin
            w  = m_mem[m_pc];
            op = w[7:5];
            ad = w[4:0];
            m_pc = m_pc + 5'd1;
            case (op)
                3'd0: begin m_a = m_mem[ad];       m_cyc += 4; exp_q.push_back(m_a); end
                3'd1: begin m_mem[ad] = m_a;       m_cyc += 3; end
                3'd2: begin m_a = m_a + m_mem[ad]; m_cyc += 4; exp_q.push_back(m_a); end
                3'd3: begin m_a = m_a - m_mem[ad]; m_cyc += 4; exp_q.push_back(m_a); end
                3'd4: begin
                    m_a = in_vals[k];
                    m_cyc += 4 + in_wait[k];
                    exp_q.push_back(m_a);
                    k = (k + 1) % 32;
                end
                3'd5: begin if (m_a == 8'd0) m_pc = ad; m_cyc += 3; end
                3'd6: begin if (!m_a[7])     m_pc = ad; m_cyc += 3; end
                default: m_cyc += 3;
            endcase
            if (op == 3'd7) break;
        end
        m_pulses = exp_q.size();
    endtask

    task automatic load_sh();
        for (int i = 0; i < 31; i++) begin
            prog_we = 1'b1; prog_addr = 5'(i); prog_data = sh[i];
            @(posedge clock); #1;
        end
        prog_we = 1'b0;
    endtask

    task automatic load_entry(input vec_t v);
        for (int i = 0; i < 32; i++) sh[i] = 8'h00;
        for (int i = 0; i < v.n; i++) sh[i] = v.code[i];
        if (v.da0 != 0) sh[v.da0] = v.dv0;
        if (v.da1 != 0) sh[v.da1] = v.dv1;
        load_sh();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        m_a = 8'h00;
    endtask

    task automatic mem_check(input string name, input logic [7:0] ref_mem [32]);
        int bad;
        bad = 0;
        for (int i = 0; i < 32; i++) if (dut.mem[i] !== ref_mem[i]) bad++;
        chk(name, 32'(bad), 32'd0);
    endtask

    task automatic start_run();
        run = 1'b1; prog_we = 1'b1; prog_addr = 5'd31; prog_data = sh[31];
        @(posedge clock); #1;
        run = 1'b0; prog_we = 1'b0;
    endtask

    // Runs the loaded program with noise on every ignored input; word 31 goes in with run
    task automatic run_prog(output int cyc, output int pulses);
        int k, idle;
        k = 0; idle = 0; cyc = 0; pulses = 0;
        m_mem = sh;
        model_run();
        start_run();
        while (!halted && cyc < 2000) begin
            if (in_ready) begin
                prog_we = 1'b0; run = 1'b0;
                if (idle >= in_wait[k]) begin
                    in_valid = 1'b1; in_data = in_vals[k]; k = (k + 1) % 32; idle = 0;
                end else begin
                    in_valid = 1'b0; in_data = 8'($urandom); idle++;
                end
            end else begin
                in_valid  = 1'($urandom); in_data   = 8'($urandom);
                prog_we   = 1'($urandom); prog_addr = 5'($urandom);
                prog_data = 8'($urandom); run       = 1'($urandom);
            end
            @(posedge clock); #1;
            cyc++;
            if (out_valid) begin
                pulses++;
                if (exp_q.size() == 0) chk("pulse_overrun", 32'(pulses), 32'(m_pulses));
                else chk("pulse_data", 32'(out_data), 32'(exp_q.pop_front()));
            end
        end
        in_valid = 1'b0; prog_we = 1'b0; run = 1'b0;
        if (!halted) chk("halt_timeout", 32'(halted), 32'd1);
        mem_check("mem_image", m_mem);
        sh = m_mem;
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_halted"},   32'(halted),    32'd1);
        chk({tag, "_in_ready"}, 32'(in_ready),  32'd0);
        chk({tag, "_out_valid"},32'(out_valid), 32'd0);
        chk({tag, "_out_data"}, 32'(out_data),  32'd0);
        chk({tag, "_aeq0"},     32'(aeq0),      32'd1);
        chk({tag, "_apos"},     32'(apos),      32'd1);
        chk({tag, "_pc"},       32'(dut.pc),    32'd0);
        chk({tag, "_ir"},       32'(dut.ir),    32'd0);
    endtask

    initial begin
        int cyc, pulses, n, ni, op, ad, wp;
        int          w_addr [10];
        logic [9:0]  w_val  [10];
        checks = 0; failures = 0;
        clock = 1'b0; reset = 1'b0; run = 1'b0; prog_we = 1'b0;
        prog_addr = '0; prog_data = '0; in_data = '0; in_valid = 1'b0;
        w_run = 1'b0; w_prog_we = 1'b0; w_prog_addr = '0; w_prog_data = '0;
        w_in_data = '0; w_in_valid = 1'b0;
        m_a = 8'h00;
        for (int i = 0; i < 32; i++) begin in_vals[i] = 8'h00; in_wait[i] = 0; end

        //       code                                                   n  da0 dv0    da1 dv1    in    w  rst  A      p  pc cyc
        tbl[0] = mk({8'h80,8'h5F,8'h3E,8'hE0,8'h00,8'h00}, 4, 31, 8'h05, 0,  8'h00, 8'h07, 3, 1, 8'h0C, 2, 4, 17);
        tbl[1] = mk({8'h1F,8'h7E,8'hA4,8'hC1,8'hE0,8'h00}, 5, 31, 8'h03, 30, 8'h01, 8'h00, 0, 0, 8'h00, 4, 5, 34);
        tbl[2] = mk({8'hA3,8'hE0,8'hE0,8'h1D,8'hDF,8'h00}, 5, 29, 8'h01, 31, 8'hC0, 8'h00, 0, 1, 8'h01, 1, 2, 19);
        tbl[3] = mk({8'hA3,8'hE0,8'hE0,8'h1D,8'hDF,8'h00}, 5, 29, 8'h01, 31, 8'h5D, 8'h00, 0, 1, 8'h02, 2, 2, 20);
        tbl[4] = mk({8'h1F,8'h5E,8'hE0,8'h00,8'h00,8'h00}, 3, 31, 8'h7F, 30, 8'h01, 8'h00, 0, 0, 8'h80, 2, 3, 11);
        tbl[5] = mk({8'h1F,8'h5E,8'h64,8'hE0,8'h81,8'h00}, 5, 31, 8'h7F, 30, 8'h01, 8'h00, 0, 0, 8'hFF, 3, 4, 15);
        tbl[6] = mk({8'h80,8'hE0,8'h00,8'h00,8'h00,8'h00}, 2, 0,  8'h00, 0,  8'h00, 8'h00, 0, 0, 8'h00, 1, 2, 7);
        tbl[7] = mk({8'h1F,8'h22,8'h00,8'h00,8'h00,8'h00}, 3, 31, 8'hE0, 0,  8'h00, 8'h00, 0, 0, 8'hE0, 1, 3, 10);

        #2 reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        check_reset_vals("init");
        reset = 1'b0;

        // Directed program table
        for (int t = 0; t < 8; t++) begin
            if (tbl[t].rst_first) do_reset();
            in_vals[0] = tbl[t].in_val; in_wait[0] = tbl[t].in_wait_c;
            load_entry(tbl[t]);
            run_prog(cyc, pulses);
            chk($sformatf("t%0d_a", t),      32'(out_data), 32'(tbl[t].exp_a));
            chk($sformatf("t%0d_pulses", t), 32'(pulses),   32'(tbl[t].exp_pulses));
            chk($sformatf("t%0d_pc", t),     32'(dut.pc),   32'(tbl[t].exp_pc));
            chk($sformatf("t%0d_cycles", t), 32'(cyc),      32'(tbl[t].exp_cycles));
            chk($sformatf("t%0d_aeq0", t),   32'(aeq0),     32'(tbl[t].exp_a == 8'h00));
            chk($sformatf("t%0d_apos", t),   32'(apos),     32'(!tbl[t].exp_a[7]));
        end

        // Async reset while waiting for input, then clean rerun
        in_vals[0] = 8'h07; in_wait[0] = 3;
        load_entry(tbl[0]);
        start_run();
        n = 0;
        while (!in_ready && n < 20) begin @(posedge clock); #1; n++; end
        chk("reach_inwait", 32'(in_ready), 32'd1);
        #2 reset = 1'b1;
        #1 check_reset_vals("rst_inwait");
        @(posedge clock); #1;
        reset = 1'b0; m_a = 8'h00;
        mem_check("rst_inwait_mem", sh);
        run_prog(cyc, pulses);
        chk("rerun_inwait_a", 32'(out_data), 32'h0C);
        chk("rerun_inwait_pulses", 32'(pulses), 32'd2);

        // Async reset in the MEM cycle of ADD
        load_entry(tbl[4]);
        start_run();
        repeat (7) @(posedge clock);
        #1;
        chk("pre_rst_mem_a", 32'(out_data), 32'h7F);
        #2 reset = 1'b1;
        #1 check_reset_vals("rst_mem");
        @(posedge clock); #1;
        reset = 1'b0; m_a = 8'h00;
        mem_check("rst_mem_mem", sh);
        run_prog(cyc, pulses);
        chk("rerun_mem_a", 32'(out_data), 32'h80);
        chk("rerun_mem_apos", 32'(apos), 32'd0);

        // Random terminating programs: forward jumps only, stores into data area
        for (int r = 0; r < 12; r++) begin
            ni = $urandom_range(4, 20);
            for (int i = 0; i < ni; i++) begin
                op = $urandom_range(0, 6);
                case (op)
                    1:       ad = $urandom_range(ni + 1, 31);
                    5, 6:    ad = $urandom_range(i + 1, ni);
                    default: ad = $urandom_range(0, 31);
                endcase
                sh[i] = {3'(op), 5'(ad)};
            end
            sh[ni] = 8'hE0;
            for (int i = ni + 1; i < 32; i++) sh[i] = 8'($urandom);
            for (int i = 0; i < 32; i++) begin
                in_vals[i] = 8'($urandom); in_wait[i] = $urandom_range(0, 3);
            end
            load_sh();
            run_prog(cyc, pulses);
            chk($sformatf("r%0d_a", r),      32'(out_data), 32'(m_a));
            chk($sformatf("r%0d_pulses", r), 32'(pulses),   32'(m_pulses));
            chk($sformatf("r%0d_pc", r),     32'(dut.pc),   32'(m_pc));
            chk($sformatf("r%0d_cycles", r), 32'(cyc),      32'(m_cyc));
            chk($sformatf("r%0d_flags", r),  32'({aeq0, apos}), 32'({m_a == 8'h00, !m_a[7]}));
        end

        // DW=10: STORE/LOAD at the top address must not alias lower words
        w_addr = '{0, 1, 2, 3, 4, 126, 125, 63, 31, 127};
        w_val  = '{10'h07E, 10'h0FF, 10'h07D, 10'h07F, 10'h380,
                   10'h2AB, 10'h155, 10'h011, 10'h022, 10'h3FF};
        for (int i = 0; i < 10; i++) begin
            w_prog_we = 1'b1; w_prog_addr = 7'(w_addr[i]); w_prog_data = w_val[i];
            @(posedge clock); #1;
        end
        w_prog_we = 1'b0;
        w_run = 1'b1;
        @(posedge clock); #1;
        w_run = 1'b0;
        n = 0; wp = 0;
        while (!w_halted && n < 100) begin
            @(posedge clock); #1; n++;
            if (w_out_valid) wp++;
        end
        chk("w_halted",  32'(w_halted),         32'd1);
        chk("w_a",       32'(w_out_data),       32'h2AB);
        chk("w_pulses",  32'(wp),               32'd3);
        chk("w_pc",      32'(dut10.pc),         32'd5);
        chk("w_mem127",  32'(dut10.mem[127]),   32'h2AB);
        chk("w_mem63",   32'(dut10.mem[63]),    32'h011);
        chk("w_mem31",   32'(dut10.mem[31]),    32'h022);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/xidoo_core.md
XIDOO_CORE -- requirements
Module: xidoo_core

Interface
REQ-001 Parameter DW, default 8, data/instruction word width; legal range 6..16.
REQ-002 Derived constant AW = DW-3, address width; DEPTH = 2**AW words of internal memory.
REQ-003 clock  in  1  master clock; every state element updates on the rising edge.
REQ-004 reset  in  1  master reset; one clock, reset asynchronous and active-high.
REQ-005 run  in  1  in HALT: start execution from address 0; ignored in all other states.
REQ-006 prog_we  in  1  program-load write strobe; honoured only in HALT.
REQ-007 prog_addr  in  AW  program-load address.
REQ-008 prog_data  in  DW  program-load word.
REQ-009 in_data  in  DW  input operand for the IN instruction.
REQ-010 in_valid  in  1  in_data is valid.
REQ-011 in_ready  out  1  core is waiting in INWAIT for an input word.
REQ-012 out_data  out  DW  accumulator A.
REQ-013 out_valid  out  1  one-cycle pulse: A was written on the previous edge.
REQ-014 aeq0  out  1  A == 0.
REQ-015 apos  out  1  A[DW-1] == 0.
REQ-016 halted  out  1  FSM is in HALT.

Function
REQ-017 Instruction word SHALL be opcode = word[DW-1:DW-3] and operand address a = word[AW-1:0].
REQ-018 Opcodes SHALL be: 000 LOAD A<=M[a]; 001 STORE M[a]<=A; 010 ADD A<=A+M[a]; 011 SUB A<=A-M[a]; 100 IN A<=in_data; 101 JZ if aeq0 PC<=a; 110 JPOS if apos PC<=a; 111 HALT.
REQ-019 ADD/SUB SHALL wrap modulo 2**DW; carry/borrow discarded, no flag.
REQ-020 Memory SHALL be single-port with synchronous read: data for the address presented in cycle n is visible in cycle n+1; write in same edge as we.
REQ-021 FSM states SHALL be HALT, FETCH, DECODE, EXEC, MEM, INWAIT.
REQ-022 HALT: memory address = prog_addr, write = prog_we; run=1 -> PC<=0, go FETCH (prog_we in the same cycle still honoured).
REQ-023 FETCH: address = PC -> DECODE.
REQ-024 DECODE: IR<=memory output, PC<=PC+1 (wraps DEPTH-1 -> 0) -> EXEC.
REQ-025 EXEC: address = IR.a; LOAD/ADD/SUB -> MEM; STORE writes A -> FETCH; JZ/JPOS update PC when condition true -> FETCH; IN -> INWAIT; HALT -> HALT.
REQ-026 MEM: A updated from memory output per opcode -> FETCH.
REQ-027 INWAIT: in_ready=1; in_valid=1 -> A<=in_data, -> FETCH; else stay.
REQ-028 Cycle counts: LOAD/ADD/SUB 4, STORE/JZ/JPOS/HALT 3, IN 3 + wait cycles (min 4).
REQ-029 in_ready SHALL be 1 only in INWAIT; in_valid outside INWAIT SHALL be ignored.
REQ-030 out_valid SHALL pulse exactly once per LOAD, ADD, SUB, IN completion and never otherwise.
REQ-031 aeq0, apos, out_data SHALL be combinational from A.
REQ-032 prog_we outside HALT SHALL not alter memory; run outside HALT SHALL have no effect.
REQ-033 A jump target or STORE to the address currently executing SHALL behave as above with no hazard logic (next FETCH reads updated memory).

Reset
REQ-034 Reset SHALL force state HALT, PC=0, IR=0, A=0, out_valid=0, in_ready=0, halted=1, aeq0=1, apos=1, asynchronously and mid-instruction.
REQ-035 Memory contents SHALL not be cleared by reset.

Verification
REQ-036 DW=8; load [0x80,0x5F,0x3E,0xE0], M[31]=5; run; in_data=7 with in_valid after 3 idle INWAIT cycles -> A=12, M[30]=12, halted=1, two out_valid pulses.
REQ-037 Load [0x1F,0x7E,0xA4,0xC1,0xE0], M[31]=3, M[30]=1; run -> halts with A=0, aeq0=1, exactly 4 out_valid pulses, PC=5.
REQ-038 LOAD of 0x7F then ADD of 0x01 -> A=0x80, apos=0; SUB of 0x81 -> A=0xFF (wrap).
REQ-039 Assert reset while in INWAIT and during MEM -> all REQ-034 values immediately, memory intact; run restarts program correctly.
REQ-040 prog_we pulses during execution -> memory unchanged; run pulses during execution -> no effect; JPOS to 0 at address 31 -> PC wrap verified.
REQ-041 DW=10 (AW=7): STORE to address 127 then LOAD 127 -> value returned, no aliasing to lower addresses.
